// File: rtl/bus6502_target.sv
// 6502 bus target: ph2-synchronised register block with a 16-bit timer.
// It also stalls selected reads through RDY using programmable wait states.
`timescale 1ns/1ps
module bus6502_target #(
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        ph2_i,
  input  logic        rwn_i,
  input  logic [15:0] a_i,
  input  logic [7:0]  d_i,
  output logic [7:0]  d_o,
  output logic        d_oe,
  output logic        rdy_o,
  output logic        irqn_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RELEASE = 2'd2
  } st_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        ph2s, ph2_d, rise, fall, sel;
  logic        acc_sel, acc_rwn;
  logic [3:0]  acc_addr;
  logic        wr, rd_fin, uf;
  logic [7:0]  wsel, rdata;
  logic [7:0]  scr0, scr1, tlo, thi, snap;
  logic        en, ar, ie, tf;
  logic [2:0]  wst;
  logic [15:0] cnt;
  st_t         state, state_nx;
  logic [2:0]  stall_cnt, stall_nx;

  assign ph2s = sync_q[SYNC_STAGES-1];
  assign rise = ph2s & ~ph2_d;
  assign fall = ~ph2s & ph2_d;
  assign sel  = (a_i[15:4] == BASE_ADDR[15:4]);
  assign wr   = fall & acc_sel & ~acc_rwn;
  assign uf   = fall & en & (cnt == 16'h0000);
  // A read only has side effects in the cycle the CPU actually completes
  assign rd_fin = fall & acc_sel & acc_rwn & (state != STALL);

  // Synchronise ph2 into clk_i and keep one delayed copy for edge detect
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      ph2_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ph2_i};
      ph2_d  <= ph2s;
    end
  end

  // Latch the access attributes at the start of each ph2 high phase
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      acc_sel  <= 1'b0;
      acc_rwn  <= 1'b1;
      acc_addr <= 4'h0;
    end else if (rise) begin
      acc_sel  <= sel;
      acc_rwn  <= rwn_i;
      acc_addr <= a_i[3:0];
    end else if (fall) begin
      acc_sel  <= 1'b0;
    end
  end

  // One-hot write strobe for the eight implemented registers
  always_comb begin
    wsel = '0;
    if (wr && !acc_addr[3])
      wsel[acc_addr[2:0]] = 1'b1;
  end

  // Read mux driven from the live address at the rise
  always_comb begin
    rdata = 8'h00;
    case (a_i[3:0])
      4'd0:    rdata = scr0;
      4'd1:    rdata = scr1;
      4'd2:    rdata = tlo;
      4'd3:    rdata = thi;
      4'd4:    rdata = {1'b0, wst, 1'b0, ie, ar, en};
      4'd5:    rdata = {7'b0, tf};
      4'd6:    rdata = cnt[7:0];
      4'd7:    rdata = snap;
      default: rdata = 8'h00;
    endcase
  end

  // Read data drive: enabled for the ph2 high phase of a selected read
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      d_o  <= 8'h00;
      d_oe <= 1'b0;
    end else if (rise && sel && rwn_i) begin
      d_o  <= rdata;
      d_oe <= 1'b1;
    end else if (fall) begin
      d_oe <= 1'b0;
    end
  end

  // Registers and timer; later assignments give load and set priority
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      scr0 <= 8'h00;
      scr1 <= 8'h00;
      tlo  <= 8'h00;
      thi  <= 8'h00;
      snap <= 8'h00;
      en   <= 1'b0;
      ar   <= 1'b0;
      ie   <= 1'b0;
      wst  <= 3'd0;
      tf   <= 1'b0;
      cnt  <= 16'h0000;
    end else begin
      if (wsel[0]) scr0 <= d_i;
      if (wsel[1]) scr1 <= d_i;
      if (wsel[2]) tlo  <= d_i;
      if (wsel[3]) thi  <= d_i;
      if (rd_fin && acc_addr == 4'd6)
        snap <= cnt[15:8];
      if (fall && en) begin
        if (cnt == 16'h0000) begin
          if (ar) begin
            cnt <= {thi, tlo};
          end else begin
            cnt <= 16'h0000;
            en  <= 1'b0;
          end
        end else begin
          cnt <= cnt - 16'd1;
        end
      end
      if (wsel[3]) begin
        cnt <= {d_i, tlo};
        en  <= 1'b1;
      end
      if (wsel[4]) begin
        en  <= d_i[0];
        ar  <= d_i[1];
        ie  <= d_i[2];
        wst <= d_i[6:4];
      end
      if (wsel[5] && d_i[0])
        tf <= 1'b0;
      if (uf)
        tf <= 1'b1;
    end
  end

  // Registered interrupt request
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) irqn_o <= 1'b1;
    else        irqn_o <= ~(tf & ie);
  end

  // Wait-state FSM state register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stall_cnt <= 3'd0;
    end else begin
      state     <= state_nx;
      stall_cnt <= stall_nx;
    end
  end

  // Wait-state FSM next state
  always_comb begin
    state_nx = state;
    stall_nx = stall_cnt;
    case (state)
      IDLE: begin
        if (rise && sel && rwn_i && wst != 3'd0) begin
          state_nx = STALL;
          stall_nx = wst;
        end
      end
      STALL: begin
        if (fall) begin
          stall_nx = stall_cnt - 3'd1;
          if (stall_cnt <= 3'd1) begin
            stall_nx = 3'd0;
            state_nx = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (fall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Wait-state FSM outputs
  always_comb begin
    rdy_o = 1'b1;
    unique case (1'b1)
      (state == STALL): rdy_o = 1'b0;
      default:          rdy_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bus6502_target.sv
// Directed bench for bus6502_target.
// Each CPU cycle is modelled as one ph2 low/high/low sequence.
`timescale 1ns/1ps
module tb_bus6502_target;

  localparam logic [15:0] B = 16'hD000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ph2_i = 1'b0;
  logic        rwn_i = 1'b1;
  logic [15:0] a_i = 16'h0000;
  logic [7:0]  d_i = 8'h00;
  logic [7:0]  d_o;
  logic        d_oe, rdy_o, irqn_o;

  int n_cmp = 0;
  int n_err = 0;

  logic       hi_doe, hi_rdy, lo_doe, lo_rdy, lo_irqn;
  logic [7:0] hi_do;

  bus6502_target #(.BASE_ADDR(B), .SYNC_STAGES(2)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .ph2_i (ph2_i),
    .rwn_i (rwn_i),
    .a_i   (a_i),
    .d_i   (d_i),
    .d_o   (d_o),
    .d_oe  (d_oe),
    .rdy_o (rdy_o),
    .irqn_o(irqn_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rw, input logic [15:0] ad,
                     input logic [7:0] wd);
    rwn_i = rw;
    a_i   = ad;
    d_i   = wd;
    #10 ph2_i = 1'b1;
    #50;
    hi_doe = d_oe;
    hi_do  = d_o;
    hi_rdy = rdy_o;
    #10 ph2_i = 1'b0;
    #60;
    lo_doe  = d_oe;
    lo_rdy  = rdy_o;
    lo_irqn = irqn_o;
    #10;
  endtask

  task automatic wr(input logic [3:0] r, input logic [7:0] v);
    cyc(1'b0, B | {12'h0, r}, v);
  endtask

  task automatic rd(input logic [3:0] r);
    cyc(1'b1, B | {12'h0, r}, 8'h00);
  endtask

  task automatic idle();
    cyc(1'b1, 16'h1000, 8'h00);
  endtask

  task automatic do_reset();
    ph2_i = 1'b0;
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    #20;
  endtask

  initial begin
    #3;
    #20;
    chk("rst_doe", d_oe, 1'b0);
    chk("rst_do", d_o, 8'h00);
    chk("rst_rdy", rdy_o, 1'b1);
    chk("rst_irqn", irqn_o, 1'b1);
    rst_n = 1'b1;
    #20;

    // scratch write / read, d_oe only in ph2 high
    wr(4'd0, 8'hA5);
    chk("wr_rdy_hi", hi_rdy, 1'b1);
    chk("wr_doe", hi_doe, 1'b0);
    rd(4'd0);
    chk("rd0_doe_hi", hi_doe, 1'b1);
    chk("rd0_do", hi_do, 8'hA5);
    chk("rd0_doe_lo", lo_doe, 1'b0);
    chk("rd0_rdy_hi", hi_rdy, 1'b1);
    chk("rd0_rdy_lo", lo_rdy, 1'b1);
    wr(4'd8, 8'hFF);
    rd(4'd8);
    chk("rd8_do", hi_do, 8'h00);
    idle();
    chk("unsel_doe", hi_doe, 1'b0);

    // one-shot timer with irq
    do_reset();
    wr(4'd2, 8'h03);
    wr(4'd3, 8'h00);
    wr(4'd4, 8'h05);
    idle();
    idle();
    chk("os_irq_f3", lo_irqn, 1'b1);
    idle();
    chk("os_irq_f4", lo_irqn, 1'b0);
    rd(4'd4);
    chk("os_ctrl", hi_do, 8'h04);
    rd(4'd6);
    chk("os_cntlo", hi_do, 8'h00);
    rd(4'd5);
    chk("os_stat", hi_do, 8'h01);
    wr(4'd5, 8'h01);
    chk("os_irq_clr", lo_irqn, 1'b1);
    rd(4'd5);
    chk("os_stat_clr", hi_do, 8'h00);

    // autoreload, count sequence and TF period
    do_reset();
    wr(4'd2, 8'h02);
    wr(4'd3, 8'h00);
    wr(4'd4, 8'h07);
    rd(4'd6); chk("ar_c0", hi_do, 8'h01);
    chk("ar_irq0", lo_irqn, 1'b1);
    rd(4'd6); chk("ar_c1", hi_do, 8'h00);
    chk("ar_irq1", lo_irqn, 1'b0);
    rd(4'd6); chk("ar_c2", hi_do, 8'h02);
    rd(4'd6); chk("ar_c3", hi_do, 8'h01);
    rd(4'd6); chk("ar_c4", hi_do, 8'h00);
    rd(4'd6); chk("ar_c5", hi_do, 8'h02);
    wr(4'd5, 8'h01);
    chk("ar_irq_clr", lo_irqn, 1'b1);
    idle();
    chk("ar_irq_again", lo_irqn, 1'b0);

    // wait states on read, none on write or unselected
    do_reset();
    wr(4'd0, 8'h5A);
    wr(4'd4, 8'h30);
    rd(4'd0); chk("ws_rdy0", hi_rdy, 1'b0);
    rd(4'd0); chk("ws_rdy1", hi_rdy, 1'b0);
    rd(4'd0); chk("ws_rdy2", hi_rdy, 1'b0);
    rd(4'd0); chk("ws_rdy3", hi_rdy, 1'b1);
    chk("ws_do", hi_do, 8'h5A);
    chk("ws_doe", hi_doe, 1'b1);
    chk("ws_rdy_lo", lo_rdy, 1'b1);
    wr(4'd1, 8'h77);
    chk("ws_wr_hi", hi_rdy, 1'b1);
    chk("ws_wr_lo", lo_rdy, 1'b1);
    idle();
    chk("ws_unsel", hi_rdy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rd(4'd1);
      chk("ws_s1_stall", hi_rdy, 1'b0);
    end
    rd(4'd1);
    chk("ws_s1_do", hi_do, 8'h77);
    chk("ws_s1_rdy", hi_rdy, 1'b1);

    // STAT clear on the underflow edge keeps TF
    do_reset();
    wr(4'd2, 8'h01);
    wr(4'd3, 8'h00);
    wr(4'd4, 8'h05);
    wr(4'd5, 8'h01);
    chk("pri_irq", lo_irqn, 1'b0);
    rd(4'd5);
    chk("pri_stat", hi_do, 8'h01);

    // CNTLO/CNTHI snapshot
    do_reset();
    wr(4'd2, 8'h34);
    wr(4'd3, 8'h12);
    rd(4'd6); chk("snap_lo", hi_do, 8'h34);
    idle();
    rd(4'd7); chk("snap_hi", hi_do, 8'h12);
    rd(4'd6); chk("snap_lo2", hi_do, 8'h31);
    wr(4'd2, 8'h00);
    wr(4'd3, 8'h01);
    rd(4'd6); chk("snap_b_lo", hi_do, 8'h00);
    rd(4'd7); chk("snap_b_hi", hi_do, 8'h01);

    // reset in the middle of a stall
    do_reset();
    wr(4'd0, 8'hA5);
    wr(4'd2, 8'h11);
    wr(4'd4, 8'h34);
    rd(4'd0);
    chk("mid_stall", hi_rdy, 1'b0);
    rwn_i = 1'b1;
    a_i   = B;
    #10 ph2_i = 1'b1;
    #30 rst_n = 1'b0;
    #1;
    chk("mid_rdy", rdy_o, 1'b1);
    chk("mid_doe", d_oe, 1'b0);
    chk("mid_do", d_o, 8'h00);
    #29 ph2_i = 1'b0;
    #60 rst_n = 1'b1;
    #10;
    for (int i = 0; i < 8; i++) begin
      rd(i[3:0]);
      chk("post_rst_reg", hi_do, 8'h00);
      chk("post_rst_rdy", hi_rdy, 1'b1);
    end
    chk("post_rst_doe", hi_doe, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
